// File: rtl/step_led_display.sv
// Registered, paged LED front-end for the step sequencer: cursor, hit pattern, page index, beat tick.
// Optional STEP_LED_DIM_EN dims non-cursor pattern LEDs with a 4-bit PWM.
module step_led_display #(
  parameter int NUM_LEDS  = 10,
  parameter int PAGE_LEDS = 8,
  parameter int NUM_STEPS = 16,
  parameter int BLINK_DIV = 12_500_000,
  parameter int DIM_DUTY  = 4,
  localparam int SW = $clog2(NUM_STEPS),
  localparam int PW = NUM_LEDS - PAGE_LEDS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SW-1:0]        beat,
  input  logic                 run,
  input  logic [PW-1:0]        page_sel,
  input  logic [NUM_STEPS-1:0] pattern,
  output logic [NUM_LEDS-1:0]  LEDR,
  output logic [PW-1:0]        page,
  output logic                 beat_tick
);

  localparam int NP = (NUM_STEPS + PAGE_LEDS - 1) / PAGE_LEDS;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  if (PW < 1 || NP > (1 << PW)) begin : g_bad_pages
    $error("step_led_display: page field cannot hold all pages");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink
    $error("step_led_display: BLINK_DIV must be >= 2");
  end
  if (DIM_DUTY < 1 || DIM_DUTY > 15) begin : g_bad_duty
    $error("step_led_display: DIM_DUTY must be 1..15");
  end

  typedef enum logic {
    HIDE = 1'b0,
    SHOW = 1'b1
  } blink_t;

  blink_t               state;
  blink_t               state_nxt;
  logic [BW-1:0]        blink_cnt;
  logic [BW-1:0]        cnt_nxt;
  logic                 blink_ph;
  logic                 wrap;
  logic [SW-1:0]        last_beat;
  logic [PW-1:0]        page_nxt;
  logic [PAGE_LEDS-1:0] pat_win;
  logic [PAGE_LEDS-1:0] cur_mask;
  logic [PAGE_LEDS-1:0] step_nxt;
  logic                 on_page;
  logic                 pg_ok;
  logic                 cur_on;
  logic                 dim;
  int                   bi;
  int                   tgt;
  int                   off;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SHOW;
      blink_cnt <= '0;
    end else begin
      state     <= state_nxt;
      blink_cnt <= cnt_nxt;
    end
  end

  assign wrap = !run && (blink_cnt == BW'(BLINK_DIV - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = blink_cnt + BW'(1);
    unique case (1'b1)
      run: begin
        state_nxt = SHOW;
        cnt_nxt   = '0;
      end
      wrap: begin
        state_nxt = (state == SHOW) ? HIDE : SHOW;
        cnt_nxt   = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    blink_ph = (state == SHOW);
  end

`ifdef STEP_LED_DIM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign dim = (pwm_cnt < 4'(DIM_DUTY));
`else
  assign dim = 1'b1;
`endif

  // An out-of-range target page keeps the previous page on display
  always_comb begin
    bi       = 32'(beat);
    tgt      = run ? (bi / PAGE_LEDS) : 32'(page_sel);
    pg_ok    = (tgt < NP) && (!run || bi < NUM_STEPS);
    page_nxt = pg_ok ? PW'(tgt) : page;
  end

  always_comb begin
    on_page  = (bi < NUM_STEPS) && ((bi / PAGE_LEDS) == 32'(page_nxt));
    off      = bi - 32'(page_nxt) * PAGE_LEDS;
    cur_mask = '0;
    if (on_page) begin
      cur_mask = PAGE_LEDS'(1) << off;
    end
    pat_win  = PAGE_LEDS'({{PAGE_LEDS{1'b0}}, pattern}
                          >> (32'(page_nxt) * PAGE_LEDS));
    cur_on   = run | blink_ph;
    step_nxt = (pat_win & ~cur_mask & {PAGE_LEDS{dim}})
             | (cur_mask & {PAGE_LEDS{cur_on}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      LEDR      <= '0;
      page      <= '0;
      beat_tick <= 1'b0;
      last_beat <= '0;
    end else begin
      LEDR      <= {page_nxt, step_nxt};
      page      <= page_nxt;
      beat_tick <= (beat != last_beat);
      last_beat <= beat;
    end
  end

endmodule
